// File: rtl/multicycle_control_fsm.sv
// Multicycle RISC-V style control unit: Moore FSM plus a Mealy pc_write and a retired-instruction counter.
// Optional build macro ILLEGAL_TRAP_EN routes unknown opcodes to a sticky TRAP state.
module multicycle_control_fsm #(
  parameter int unsigned RETIRE_CNT_W = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              op_code,
  input  logic                    zero,
  input  logic                    mem_ready,
  output logic                    pc_write,
  output logic                    adr_src,
  output logic                    ir_write,
  output logic                    mem_write,
  output logic                    reg_write,
  output logic [1:0]              result_src,
  output logic [1:0]              alu_src_a,
  output logic [1:0]              alu_src_b,
  output logic [1:0]              alu_op,
  output logic [1:0]              imm_src,
  output logic                    instr_retired,
  output logic [RETIRE_CNT_W-1:0] instret,
  output logic                    illegal_instr
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECUTER = 4'd6;
  localparam logic [3:0] S_EXECUTEI = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BEQ      = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;
  localparam logic [3:0] S_TRAP     = 4'd11;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  logic [3:0]              r_state;
  logic [3:0]              w_state_next;
  logic                    w_pc_update;
  logic                    w_branch;
  logic                    w_retire;
  logic                    r_retired;
  logic [RETIRE_CNT_W-1:0] r_instret;

  // State register; reset lands in FETCH from any state, including a pending memory wait.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_FETCH;
      r_retired <= 1'b0;
      r_instret <= '0;
    end else begin
      r_state   <= w_state_next;
      r_retired <= w_retire;
      if (w_retire) r_instret <= r_instret + RETIRE_CNT_W'(1);
    end
  end

  // Next-state and Moore output decode.
  always_comb begin
    w_state_next = r_state;
    w_pc_update  = 1'b0;
    w_branch     = 1'b0;
    w_retire     = 1'b0;
    adr_src      = 1'b0;
    ir_write     = 1'b0;
    mem_write    = 1'b0;
    reg_write    = 1'b0;
    result_src   = 2'b00;
    alu_src_a    = 2'b00;
    alu_src_b    = 2'b00;
    alu_op       = 2'b00;
    case (r_state)
      S_FETCH: begin
        alu_src_b   = 2'b10;
        result_src  = 2'b10;
        ir_write    = mem_ready;
        w_pc_update = mem_ready;
        if (mem_ready) w_state_next = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (op_code)
          OP_LOAD, OP_STORE: w_state_next = S_MEMADR;
          OP_RTYPE:          w_state_next = S_EXECUTER;
          OP_ITYPE:          w_state_next = S_EXECUTEI;
          OP_BEQ:            w_state_next = S_BEQ;
          OP_JAL:            w_state_next = S_JAL;
`ifdef ILLEGAL_TRAP_EN
          default:           w_state_next = S_TRAP;
`else
          default:           w_state_next = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: begin
        alu_src_a    = 2'b10;
        alu_src_b    = 2'b01;
        w_state_next = op_code[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        if (mem_ready) w_state_next = S_MEMWB;
      end
      S_MEMWB: begin
        result_src   = 2'b01;
        reg_write    = 1'b1;
        w_retire     = 1'b1;
        w_state_next = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) begin
          w_retire     = 1'b1;
          w_state_next = S_FETCH;
        end
      end
      S_EXECUTER: begin
        alu_src_a    = 2'b10;
        alu_op       = 2'b11;
        w_state_next = S_ALUWB;
      end
      S_EXECUTEI: begin
        alu_src_a    = 2'b10;
        alu_src_b    = 2'b01;
        alu_op       = 2'b11;
        w_state_next = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write    = 1'b1;
        w_retire     = 1'b1;
        w_state_next = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a    = 2'b10;
        alu_op       = 2'b01;
        w_branch     = 1'b1;
        w_retire     = 1'b1;
        w_state_next = S_FETCH;
      end
      S_JAL: begin
        alu_src_a    = 2'b01;
        alu_src_b    = 2'b10;
        w_pc_update  = 1'b1;
        w_state_next = S_ALUWB;
      end
      S_TRAP:  w_state_next = S_TRAP;
      default: w_state_next = S_FETCH;
    endcase
  end

  assign pc_write      = w_pc_update | (w_branch & zero);
  assign instr_retired = r_retired;
  assign instret       = r_instret;

  // Immediate format follows the opcode in every state.
  always_comb begin
    case (op_code)
      OP_STORE: imm_src = 2'b01;
      OP_BEQ:   imm_src = 2'b10;
      OP_JAL:   imm_src = 2'b11;
      default:  imm_src = 2'b00;
    endcase
  end

`ifdef ILLEGAL_TRAP_EN
  logic r_illegal;

  // Sticky until reset; rises together with entry into TRAP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_illegal <= 1'b0;
    else if (w_state_next == S_TRAP) r_illegal <= 1'b1;
  end

  assign illegal_instr = r_illegal;
`else
  assign illegal_instr = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed self-checking bench for multicycle_control_fsm; expected control words are hand-computed.
module tb_multicycle_control_fsm;

  logic        clk;
  logic        rst_n;
  logic [6:0]  op_code;
  logic        zero;
  logic        mem_ready;
  logic        pc_write, adr_src, ir_write, mem_write, reg_write;
  logic [1:0]  result_src, alu_src_a, alu_src_b, alu_op, imm_src;
  logic        instr_retired;
  logic [31:0] instret;
  logic        illegal_instr;
  logic [12:0] ctl;

  int n_checks = 0;
  int n_fail   = 0;

  // ctl = {pc_write, adr_src, ir_write, mem_write, reg_write, result_src, alu_src_a, alu_src_b, alu_op}
  localparam logic [12:0] C_FETCH1   = 13'b1_0_1_0_0_10_00_10_00;
  localparam logic [12:0] C_FETCH0   = 13'b0_0_0_0_0_10_00_10_00;
  localparam logic [12:0] C_DECODE   = 13'b0_0_0_0_0_00_01_01_00;
  localparam logic [12:0] C_MEMADR   = 13'b0_0_0_0_0_00_10_01_00;
  localparam logic [12:0] C_MEMREAD  = 13'b0_1_0_0_0_00_00_00_00;
  localparam logic [12:0] C_MEMWB    = 13'b0_0_0_0_1_01_00_00_00;
  localparam logic [12:0] C_MEMWRITE = 13'b0_1_0_1_0_00_00_00_00;
  localparam logic [12:0] C_EXECR    = 13'b0_0_0_0_0_00_10_00_11;
  localparam logic [12:0] C_EXECI    = 13'b0_0_0_0_0_00_10_01_11;
  localparam logic [12:0] C_ALUWB    = 13'b0_0_0_0_1_00_00_00_00;
  localparam logic [12:0] C_BEQ_T    = 13'b1_0_0_0_0_00_10_00_01;
  localparam logic [12:0] C_BEQ_N    = 13'b0_0_0_0_0_00_10_00_01;
  localparam logic [12:0] C_JAL      = 13'b1_0_0_0_0_00_01_10_00;
  localparam logic [12:0] C_ZERO     = 13'b0_0_0_0_0_00_00_00_00;

  assign ctl = {pc_write, adr_src, ir_write, mem_write, reg_write,
                result_src, alu_src_a, alu_src_b, alu_op};

  multicycle_control_fsm #(.RETIRE_CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .op_code(op_code), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .adr_src(adr_src), .ir_write(ir_write), .mem_write(mem_write),
    .reg_write(reg_write), .result_src(result_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .imm_src(imm_src),
    .instr_retired(instr_retired), .instret(instret), .illegal_instr(illegal_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    op_code   = 7'b0110011;
    zero      = 1'b0;
    mem_ready = 1'b1;
    #3;
    chk("rst_ctl_mr1", 32'(ctl), 32'(C_FETCH1));
    chk("rst_instret", instret, 32'd0);
    chk("rst_retired", 32'(instr_retired), 32'd0);
    chk("rst_illegal", 32'(illegal_instr), 32'd0);
    mem_ready = 1'b0;
    #1;
    chk("rst_ctl_mr0", 32'(ctl), 32'(C_FETCH0));
    mem_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // R-type
    chk("r_fetch", 32'(ctl), 32'(C_FETCH1));
    chk("r_imm", 32'(imm_src), 32'd0);
    tick(); chk("r_decode", 32'(ctl), 32'(C_DECODE));
    chk("r_dec_ret", 32'(instr_retired), 32'd0);
    tick(); chk("r_execr", 32'(ctl), 32'(C_EXECR));
    tick(); chk("r_aluwb", 32'(ctl), 32'(C_ALUWB));
    chk("r_aluwb_cnt", instret, 32'd0);
    op_code = 7'b0000011;
    tick(); chk("r_ret", 32'(instr_retired), 32'd1);
    chk("r_cnt", instret, 32'd1);

    // lw with three wait cycles in MEMREAD
    chk("lw_fetch", 32'(ctl), 32'(C_FETCH1));
    chk("lw_imm", 32'(imm_src), 32'd0);
    tick(); chk("lw_decode", 32'(ctl), 32'(C_DECODE));
    chk("lw_dec_ret", 32'(instr_retired), 32'd0);
    tick(); chk("lw_memadr", 32'(ctl), 32'(C_MEMADR));
    mem_ready = 1'b0;
    tick(); chk("lw_rd1", 32'(ctl), 32'(C_MEMREAD));
    tick(); chk("lw_rd2", 32'(ctl), 32'(C_MEMREAD));
    tick(); chk("lw_rd3", 32'(ctl), 32'(C_MEMREAD));
    mem_ready = 1'b1;
    #1; chk("lw_rd4", 32'(ctl), 32'(C_MEMREAD));
    tick(); chk("lw_memwb", 32'(ctl), 32'(C_MEMWB));
    op_code = 7'b0100011;
    tick(); chk("lw_after_wb", 32'(ctl), 32'(C_FETCH1));
    chk("lw_ret", 32'(instr_retired), 32'd1);
    chk("lw_cnt", instret, 32'd2);

    // sw with two wait cycles in MEMWRITE
    chk("sw_imm", 32'(imm_src), 32'd1);
    tick(); chk("sw_decode", 32'(ctl), 32'(C_DECODE));
    tick(); chk("sw_memadr", 32'(ctl), 32'(C_MEMADR));
    mem_ready = 1'b0;
    tick(); chk("sw_wr1", 32'(ctl), 32'(C_MEMWRITE));
    tick(); chk("sw_wr2", 32'(ctl), 32'(C_MEMWRITE));
    chk("sw_wr2_ret", 32'(instr_retired), 32'd0);
    mem_ready = 1'b1;
    #1; chk("sw_wr3", 32'(ctl), 32'(C_MEMWRITE));
    op_code = 7'b1100011;
    tick(); chk("sw_ret", 32'(instr_retired), 32'd1);
    chk("sw_cnt", instret, 32'd3);

    // beq taken then not taken
    chk("beq_imm", 32'(imm_src), 32'd2);
    tick(); tick();
    zero = 1'b1;
    #1; chk("beq_taken", 32'(ctl), 32'(C_BEQ_T));
    zero = 1'b0;
    #1; chk("beq_pcw0", 32'(ctl), 32'(C_BEQ_N));
    zero = 1'b1;
    tick(); chk("beq1_ret", 32'(instr_retired), 32'd1);
    chk("beq1_cnt", instret, 32'd4);
    zero = 1'b0;
    tick(); tick(); chk("beq_not", 32'(ctl), 32'(C_BEQ_N));
    op_code = 7'b1101111;
    tick(); chk("beq2_ret", 32'(instr_retired), 32'd1);
    chk("beq2_cnt", instret, 32'd5);

    // jal
    chk("jal_imm", 32'(imm_src), 32'd3);
    tick(); chk("jal_decode", 32'(ctl), 32'(C_DECODE));
    tick(); chk("jal_state", 32'(ctl), 32'(C_JAL));
    tick(); chk("jal_aluwb", 32'(ctl), 32'(C_ALUWB));
    op_code = 7'b0010011;
    tick(); chk("jal_cnt", instret, 32'd6);

    // I-type, with fetch stall first
    mem_ready = 1'b0;
    #1; chk("i_fetch_wait", 32'(ctl), 32'(C_FETCH0));
    tick(); chk("i_fetch_hold", 32'(ctl), 32'(C_FETCH0));
    chk("i_ret_pulse_end", 32'(instr_retired), 32'd0);
    mem_ready = 1'b1;
    tick(); tick(); chk("i_execi", 32'(ctl), 32'(C_EXECI));
    tick(); chk("i_aluwb", 32'(ctl), 32'(C_ALUWB));
    op_code = 7'b1111111;
    tick(); chk("i_cnt", instret, 32'd7);

    // Unknown opcode
    chk("ill_imm", 32'(imm_src), 32'd0);
    tick(); chk("ill_decode", 32'(ctl), 32'(C_DECODE));
    tick();
`ifdef ILLEGAL_TRAP_EN
    chk("ill_trap_ctl", 32'(ctl), 32'(C_ZERO));
    chk("ill_flag", 32'(illegal_instr), 32'd1);
    tick(); chk("ill_trap_stay", 32'(ctl), 32'(C_ZERO));
    chk("ill_flag_sticky", 32'(illegal_instr), 32'd1);
    rst_n = 1'b0;
    #1; chk("ill_rst_flag", 32'(illegal_instr), 32'd0);
    rst_n = 1'b1;
`else
    chk("ill_nop_fetch", 32'(ctl), 32'(C_FETCH1));
    chk("ill_no_ret", 32'(instr_retired), 32'd0);
    chk("ill_cnt", instret, 32'd7);
    chk("ill_flag_tied", 32'(illegal_instr), 32'd0);
`endif

    // Async reset during a pending MEMWRITE wait
    op_code = 7'b0100011;
    tick(); tick();
    mem_ready = 1'b0;
    tick(); chk("rw_memwrite", 32'(ctl), 32'(C_MEMWRITE));
    rst_n = 1'b0;
    #1;
    chk("rw_rst_ctl", 32'(ctl), 32'(C_FETCH0));
    chk("rw_rst_cnt", instret, 32'd0);
    chk("rw_rst_ret", 32'(instr_retired), 32'd0);
    tick(); chk("rw_rst_hold", 32'(ctl), 32'(C_FETCH0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
